uart_tx_sched: RTL and testbench

Scheduler that shares the single UART transmitter (byte_ready / t_byte / shift FSM) between N_REQ byte producers, e.g. the core's MMIO store path and the debug/trace unit. It arbitrates round-robin and supports packet locking. For each accepted byte it sequences the transmitter handshake (load, trigger, wait for completion) and optionally enforces an inter-frame idle gap. It sits between the requesters and the transmitter's data register and FSM inputs.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_tx_sched_if.sv | 28 ++
 rtl/uart_rr_arbiter.sv | 31 +++
 rtl/uart_tx_sched.sv | 135 +++++++++++++
 tb/tb_uart_tx_sched.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_pkg;

  localparam int unsigned UART_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT,
    GAP
  } sched_state_e;

endpackage

// File: rtl/uart_tx_sched_if.sv
// Requester-side valid/ready byte bus shared by all producers of the UART scheduler.
interface uart_tx_sched_if
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ  = 2,
  parameter int unsigned DATA_W = UART_DATA_W
);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_last;
  logic [N_REQ-1:0]        req_ready;

  modport master (
    output req_valid,
    output req_data,
    output req_last,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  req_last,
    output req_ready
  );

endinterface

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin pick: first eligible index after the pointer, wrapping.
module uart_rr_arbiter #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] eligible_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    cand  = '0;
    found = 1'b0;
    idx_o = '0;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      cand = IDX_W'((32'(ptr_i) + off) % N_REQ);
      if (!found && eligible_i[cand]) begin
        found = 1'b1;
        idx_o = cand;
      end
    end
    any_o   = found;
    grant_o = found ? (N_REQ'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter between N_REQ byte producers: round-robin with
// packet locking, load/start/wait handshake sequencing and an optional idle gap.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ      = 2,
  parameter int unsigned DATA_W     = UART_DATA_W,
  parameter int unsigned GAP_CYCLES = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en_i,
  uart_tx_sched_if.slave     req_if,
  output logic [N_REQ-1:0]   grant_o,
  output logic [DATA_W-1:0]  tx_data_o,
  output logic               tx_byte_ready_o,
  output logic               tx_t_byte_o,
  input  logic               tx_done_i,
  output logic               busy_o
);

  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  sched_state_e      state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic              lock_q, lock_d;
  logic [GAP_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [N_REQ-1:0]  grant_q, grant_d;

  logic [N_REQ-1:0]  eligible;
  logic [N_REQ-1:0]  win_grant;
  logic [IDX_W-1:0]  win_idx;
  logic              win_any;
  logic [DATA_W-1:0] sel_data;
  logic              accept_c;
  logic [N_REQ-1:0]  ready_c;

  // A set lock restricts arbitration to the previous winner until it sends last=1.
  assign eligible = lock_q ? (req_if.req_valid & (N_REQ'(1) << ptr_q)) : req_if.req_valid;

  uart_rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .eligible_i (eligible),
    .ptr_i      (ptr_q),
    .grant_o    (win_grant),
    .idx_o      (win_idx),
    .any_o      (win_any)
  );

  always_comb begin
    sel_data = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (win_idx == IDX_W'(k)) sel_data = req_if.req_data[k*DATA_W +: DATA_W];
    end
  end

  assign accept_c = rst_ni && en_i && (state_q == IDLE) && win_any;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (en_i) begin
      case (state_q)
        IDLE:    if (win_any) state_d = LOAD;
        LOAD:    state_d = START;
        START:   state_d = WAIT;
        WAIT:    if (tx_done_i) state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
        GAP:     if (cnt_q == '0) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    ready_c         = '0;
    tx_byte_ready_o = 1'b0;
    tx_t_byte_o     = 1'b0;
    ptr_d           = ptr_q;
    lock_d          = lock_q;
    cnt_d           = cnt_q;
    data_d          = data_q;
    grant_d         = grant_q;
    if (accept_c) begin
      ready_c = win_grant;
      data_d  = sel_data;
      grant_d = win_grant;
      ptr_d   = win_idx;
      lock_d  = ~req_if.req_last[win_idx];
    end
    if (en_i) begin
      case (state_q)
        LOAD:  tx_byte_ready_o = 1'b1;
        START: tx_t_byte_o     = 1'b1;
        WAIT: begin
          if (tx_done_i) begin
            grant_d = '0;
            if (GAP_CYCLES != 0) cnt_d = GAP_W'(GAP_CYCLES - 1);
          end
        end
        GAP:     if (cnt_q != '0) cnt_d = cnt_q - GAP_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q   <= IDX_W'(N_REQ - 1);
      lock_q  <= 1'b0;
      cnt_q   <= '0;
      data_q  <= '0;
      grant_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      lock_q  <= lock_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      grant_q <= grant_d;
    end
  end

  assign req_if.req_ready = ready_c;
  assign grant_o          = grant_q;
  assign tx_data_o        = data_q;
  assign busy_o           = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: stimulus pushes expected frames, a monitor
// compares them on every transmitter start pulse.
module tb_uart_tx_sched;
  import uart_pkg::*;

  localparam int unsigned N   = 2;
  localparam int unsigned W   = 8;
  localparam int unsigned GAP = 16;

  typedef struct packed {
    logic [W-1:0] data;
    logic [N-1:0] grant;
  } exp_t;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         en_i;
  logic         tx_done_i;
  logic [N-1:0] grant_o;
  logic [W-1:0] tx_data_o;
  logic         tx_byte_ready_o;
  logic         tx_t_byte_o;
  logic         busy_o;

  int   tests = 0;
  int   errs  = 0;
  exp_t q[$];

  always #5 clk_i = ~clk_i;

  uart_tx_sched_if #(.N_REQ(N), .DATA_W(W)) rif ();

  uart_tx_sched #(
    .N_REQ      (N),
    .DATA_W     (W),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .en_i            (en_i),
    .req_if          (rif),
    .grant_o         (grant_o),
    .tx_data_o       (tx_data_o),
    .tx_byte_ready_o (tx_byte_ready_o),
    .tx_t_byte_o     (tx_t_byte_o),
    .tx_done_i       (tx_done_i),
    .busy_o          (busy_o)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Scoreboard monitor: every start pulse must match the oldest expected frame.
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (tx_t_byte_o === 1'b1) begin
        if (q.size() == 0) check("unexpected_frame", 32'(tx_data_o), 32'hFFFF);
        else begin
          e = q.pop_front();
          check("frame_data", 32'(tx_data_o), 32'(e.data));
          check("frame_grant", 32'(grant_o), 32'(e.grant));
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_ready(output logic [N-1:0] r);
    r = '0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      if (|rif.req_ready) begin
        r = rif.req_ready;
        return;
      end
    end
    check("ready_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_tbyte;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      if (tx_t_byte_o) begin
        tick();
        return;
      end
    end
    check("tbyte_timeout", 32'd1, 32'd0);
  endtask

  task automatic pulse_done;
    tx_done_i = 1'b1;
    tick();
    tx_done_i = 1'b0;
  endtask

  task automatic check_gap(input bit spurious);
    int n;
    n = 0;
    tx_done_i = spurious;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      tx_done_i = 1'b0;
      if (i == 0) check("gap_grant", 32'(grant_o), 32'd0);
      if (!busy_o) break;
      n++;
    end
    check("gap_len", 32'(n), 32'(GAP));
  endtask

  task automatic do_reset;
    rst_ni = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
  endtask

  initial begin : stim
    logic [N-1:0] r;
    int k;
    rst_ni        = 1'b0;
    en_i          = 1'b1;
    tx_done_i     = 1'b0;
    rif.req_valid = 2'b01;
    rif.req_data  = {8'h00, 8'hA5};
    rif.req_last  = 2'b01;

    // Reset state with a requester already valid.
    @(negedge clk_i);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_grant", 32'(grant_o), 32'd0);
    check("rst_data", 32'(tx_data_o), 32'd0);
    check("rst_ready", 32'(rif.req_ready), 32'd0);
    check("rst_pulses", 32'({tx_byte_ready_o, tx_t_byte_o}), 32'd0);

    // Single byte: latency of load/start pulses, hold and gap length.
    q.push_back('{data: 8'hA5, grant: 2'b01});
    tick();
    rst_ni = 1'b1;
    wait_ready(r);
    check("t1_ready", 32'(r), 32'h1);
    tick();
    rif.req_valid = '0;
    @(negedge clk_i);
    check("t1_byte_ready", 32'(tx_byte_ready_o), 32'd1);
    check("t1_tbyte_early", 32'(tx_t_byte_o), 32'd0);
    check("t1_data", 32'(tx_data_o), 32'hA5);
    check("t1_grant", 32'(grant_o), 32'h1);
    check("t1_busy", 32'(busy_o), 32'd1);
    tick();
    @(negedge clk_i);
    check("t1_tbyte", 32'(tx_t_byte_o), 32'd1);
    tick();
    repeat (4) tick();
    @(negedge clk_i);
    check("t1_hold_data", 32'(tx_data_o), 32'hA5);
    check("t1_wait_pulses", 32'({tx_byte_ready_o, tx_t_byte_o}), 32'd0);
    tick();
    pulse_done();
    check_gap(1'b0);

    // Both valid continuously: strict alternation from reset.
    do_reset();
    rif.req_data = {8'h22, 8'h11};
    rif.req_last = 2'b11;
    q.push_back('{data: 8'h11, grant: 2'b01});
    q.push_back('{data: 8'h22, grant: 2'b10});
    q.push_back('{data: 8'h11, grant: 2'b01});
    q.push_back('{data: 8'h22, grant: 2'b10});
    rif.req_valid = 2'b11;
    for (int f = 0; f < 4; f++) begin
      wait_tbyte();
      if (f == 3) rif.req_valid = '0;
      pulse_done();
      check_gap(1'b0);
    end

    // Packet lock: requester 0 keeps the grant, even while it pauses.
    tick();
    rif.req_data  = {8'h44, 8'h01};
    rif.req_last  = 2'b10;
    rif.req_valid = 2'b11;
    q.push_back('{data: 8'h01, grant: 2'b01});
    q.push_back('{data: 8'h02, grant: 2'b01});
    q.push_back('{data: 8'h03, grant: 2'b01});
    q.push_back('{data: 8'h44, grant: 2'b10});
    wait_ready(r);
    check("t3_ready_b1", 32'(r), 32'h1);
    tick();
    rif.req_data[7:0] = 8'h02;
    rif.req_valid[0]  = 1'b0;
    wait_tbyte();
    pulse_done();
    k = 0;
    repeat (30) begin
      @(negedge clk_i);
      if (|rif.req_ready) k++;
    end
    check("t3_lock_stall", 32'(k), 32'd0);
    tick();
    rif.req_valid[0] = 1'b1;
    wait_ready(r);
    check("t3_ready_b2", 32'(r), 32'h1);
    tick();
    rif.req_data[7:0] = 8'h03;
    rif.req_last[0]   = 1'b1;
    wait_tbyte();
    pulse_done();
    wait_ready(r);
    check("t3_ready_b3", 32'(r), 32'h1);
    tick();
    rif.req_valid[0] = 1'b0;
    wait_tbyte();
    pulse_done();
    wait_ready(r);
    check("t3_ready_other", 32'(r), 32'h2);
    tick();
    rif.req_valid = '0;
    wait_tbyte();
    pulse_done();
    check_gap(1'b0);

    // Done pulses outside WAIT are ignored.
    tick();
    rif.req_data  = {8'h00, 8'h5A};
    rif.req_last  = 2'b01;
    rif.req_valid = 2'b01;
    q.push_back('{data: 8'h5A, grant: 2'b01});
    wait_ready(r);
    check("t4_ready", 32'(r), 32'h1);
    tick();
    rif.req_valid = '0;
    tx_done_i     = 1'b1;
    tick();
    tx_done_i = 1'b0;
    @(negedge clk_i);
    check("t4_tbyte", 32'(tx_t_byte_o), 32'd1);
    tick();
    repeat (10) tick();
    @(negedge clk_i);
    check("t4_still_wait_grant", 32'(grant_o), 32'h1);
    check("t4_still_busy", 32'(busy_o), 32'd1);
    tick();
    pulse_done();
    check_gap(1'b1);

    // en_i low while in START withholds the start pulse.
    tick();
    rif.req_data  = {8'h00, 8'hC3};
    rif.req_valid = 2'b01;
    q.push_back('{data: 8'hC3, grant: 2'b01});
    wait_ready(r);
    check("t5_ready", 32'(r), 32'h1);
    tick();
    rif.req_valid = '0;
    tick();
    en_i = 1'b0;
    k = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      if (tx_t_byte_o || !busy_o) k++;
      tick();
    end
    check("t5_frozen", 32'(k), 32'd0);
    en_i = 1'b1;
    @(negedge clk_i);
    check("t5_tbyte_after_en", 32'(tx_t_byte_o), 32'd1);
    tick();
    pulse_done();
    check_gap(1'b0);

    // Reset in WAIT with the lock set.
    tick();
    rif.req_data  = {8'h00, 8'h77};
    rif.req_last  = 2'b00;
    rif.req_valid = 2'b01;
    q.push_back('{data: 8'h77, grant: 2'b01});
    wait_tbyte();
    rif.req_valid = 2'b10;
    repeat (2) tick();
    rst_ni = 1'b0;
    #1;
    check("t6_rst_grant", 32'(grant_o), 32'd0);
    check("t6_rst_data", 32'(tx_data_o), 32'd0);
    check("t6_rst_busy", 32'(busy_o), 32'd0);
    check("t6_rst_ready", 32'(rif.req_ready), 32'd0);
    tick();
    rif.req_data  = {8'h99, 8'h88};
    rif.req_last  = 2'b11;
    rif.req_valid = 2'b11;
    q.push_back('{data: 8'h88, grant: 2'b01});
    q.push_back('{data: 8'h99, grant: 2'b10});
    tick();
    rst_ni = 1'b1;
    wait_ready(r);
    check("t6_first_after_rst", 32'(r), 32'h1);
    tick();
    rif.req_valid[0] = 1'b0;
    wait_tbyte();
    pulse_done();
    wait_ready(r);
    check("t6_second_after_rst", 32'(r), 32'h2);
    tick();
    rif.req_valid = '0;
    wait_tbyte();
    pulse_done();
    check_gap(1'b0);

    check("queue_empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule
